pipeline_ctrl: RTL

Central stall/flush sequencer for the six-stage tartaruga pipeline (fetch, decode, rr, exe, mem, wb). It turns stage valids, hazard information and busy/redirect events into per-stage-register stall and flush controls. It also issues the registered fetch redirect after a taken branch and drains the back end for serializing instructions. It sits beside `datapath` and drives its `stall_*`/`flush_*` nets plus `fetch.taken_branch_i`/`new_pc_i`.

---
 rtl/tartaruga_pkg.sv | 25 ++
 rtl/load_use_check.sv | 25 ++
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga pipeline control path.
package tartaruga_pkg;

    // Sequencer states: normal flow, one-cycle fetch redirect, back-end drain.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } pipe_ctrl_state_t;

    // Stall/flush bits for each stage register (register named after the stage feeding it).
    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic stall_rr;
        logic stall_exe;
        logic stall_mem;
        logic flush_fetch;
        logic flush_decode;
        logic flush_rr;
        logic flush_exe;
        logic flush_mem;
    } stage_ctrl_t;

endpackage

// File: rtl/load_use_check.sv
// Detects a load in exe whose destination is read by the instruction in rr.
// Stage valids are applied by the caller; x0 never produces a hazard.
module load_use_check #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rr_rs1,
    input  logic [REG_ADDR_W-1:0] rr_rs2,
    input  logic                  rr_use_rs1,
    input  logic                  rr_use_rs2,
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic                  exe_is_load,
    input  logic                  exe_regwrite,
    output logic                  hazard
);

    logic rd_live;

    // A hazard needs a real destination and a matching, actually-used source.
    always_comb begin
        rd_live = exe_is_load & exe_regwrite & (exe_rd != '0);
        hazard  = rd_live & ((rr_use_rs1 & (rr_rs1 == exe_rd)) |
                             (rr_use_rs2 & (rr_rs2 == exe_rd)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the six-stage pipeline, with registered fetch
// redirect after taken branches and back-end drain for serializing ops.
// Handshake note: a stage register advances when neither its stall nor its
// flush is set; flush loads a bubble, stall holds; both are never set together.
module pipeline_ctrl
    import tartaruga_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  valid_rr_i,
    input  logic                  valid_exe_i,
    input  logic                  valid_mem_i,
    input  logic                  valid_wb_i,
    input  logic [REG_ADDR_W-1:0] rr_rs1_i,
    input  logic [REG_ADDR_W-1:0] rr_rs2_i,
    input  logic                  rr_use_rs1_i,
    input  logic                  rr_use_rs2_i,
    input  logic                  rr_serialize_i,
    input  logic [REG_ADDR_W-1:0] exe_rd_i,
    input  logic                  exe_regwrite_i,
    input  logic                  exe_is_load_i,
    input  logic                  exe_busy_i,
    input  logic                  mem_busy_i,
    input  logic                  taken_branch_i,
    input  logic [31:0]           branch_pc_i,
    output logic                  stall_fetch_o,
    output logic                  stall_decode_o,
    output logic                  stall_rr_o,
    output logic                  stall_exe_o,
    output logic                  stall_mem_o,
    output logic                  flush_fetch_o,
    output logic                  flush_decode_o,
    output logic                  flush_rr_o,
    output logic                  flush_exe_o,
    output logic                  flush_mem_o,
    output logic                  redirect_o,
    output logic [31:0]           redirect_pc_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_events_o,
    output pipe_ctrl_state_t      state_o
);

    pipe_ctrl_state_t state_q, state_d;
    stage_ctrl_t      ctrl;
    logic             accept_branch;
    logic             lu_hazard;
    logic             serialize_hold;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    load_use_check #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .rr_rs1       (rr_rs1_i),
        .rr_rs2       (rr_rs2_i),
        .rr_use_rs1   (rr_use_rs1_i),
        .rr_use_rs2   (rr_use_rs2_i),
        .exe_rd       (exe_rd_i),
        .exe_is_load  (exe_is_load_i),
        .exe_regwrite (exe_regwrite_i),
        .hazard       (lu_hazard)
    );

    // Prioritised next-state and stall/flush decode; outputs forced low in reset.
    always_comb begin
        ctrl           = '0;
        state_d        = state_q;
        accept_branch  = 1'b0;
        serialize_hold = valid_rr_i & rr_serialize_i & (valid_exe_i | valid_mem_i | valid_wb_i);
        if (mem_busy_i) begin
            ctrl.stall_fetch  = 1'b1;
            ctrl.stall_decode = 1'b1;
            ctrl.stall_rr     = 1'b1;
            ctrl.stall_exe    = 1'b1;
            ctrl.flush_mem    = 1'b1;
            // Fetch consumes the redirect regardless of stalls, so REDIRECT never repeats.
            if (state_q == REDIRECT) state_d = RUN;
        end else if (exe_busy_i) begin
            ctrl.stall_fetch  = 1'b1;
            ctrl.stall_decode = 1'b1;
            ctrl.stall_rr     = 1'b1;
            ctrl.flush_exe    = 1'b1;
            if (state_q == REDIRECT) state_d = RUN;
        end else if (taken_branch_i && valid_exe_i) begin
            ctrl.flush_fetch  = 1'b1;
            ctrl.flush_decode = 1'b1;
            ctrl.flush_rr     = 1'b1;
            accept_branch     = 1'b1;
            state_d           = REDIRECT;
        end else if (state_q == REDIRECT) begin
            ctrl.flush_fetch  = 1'b1;
            state_d           = RUN;
        end else if (serialize_hold) begin
            ctrl.stall_fetch  = 1'b1;
            ctrl.stall_decode = 1'b1;
            ctrl.flush_rr     = 1'b1;
            state_d           = DRAIN;
        end else begin
            // Back end empty (or nothing to serialize): DRAIN ends, rr advances.
            state_d = RUN;
            if (valid_rr_i && valid_exe_i && lu_hazard) begin
                ctrl.stall_fetch  = 1'b1;
                ctrl.stall_decode = 1'b1;
                ctrl.flush_rr     = 1'b1;
            end
        end
        if (!rstn_i) begin
            ctrl          = '0;
            accept_branch = 1'b0;
        end
    end

    // State, redirect target and performance counters.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept_branch) begin
                redirect_pc_q <= branch_pc_i;
                flush_cnt_q   <= flush_cnt_q + CNT_W'(1);
            end
            if (ctrl.stall_fetch && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_fetch_o  = ctrl.stall_fetch;
    assign stall_decode_o = ctrl.stall_decode;
    assign stall_rr_o     = ctrl.stall_rr;
    assign stall_exe_o    = ctrl.stall_exe;
    assign stall_mem_o    = ctrl.stall_mem;
    assign flush_fetch_o  = ctrl.flush_fetch;
    assign flush_decode_o = ctrl.flush_decode;
    assign flush_rr_o     = ctrl.flush_rr;
    assign flush_exe_o    = ctrl.flush_exe;
    assign flush_mem_o    = ctrl.flush_mem;
    assign redirect_o     = (state_q == REDIRECT);
    assign redirect_pc_o  = redirect_pc_q;
    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
    assign state_o        = state_q;

endmodule
